instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-side responder to the processor controller. Owns the program counter, the
//  instruction RAM and the stage (instruction) register. Answers the controller's fetch
//  strobes and returns decoded fields (opcode, address mode, address) that the controller
//  sequences on. Sits between controller and instruction memory, upstream of the datapath.
// PARAMETERS
//  IW     16  instruction width; word = {opcode[15:11], addr_mode[10:8], addr[7:0]}
//  AW      8  PC / instruction RAM address width; RAM depth = 2**AW words
// PORTS
//  clk                    in   1   single clock, all state updates on rising edge
//  reset                  in   1   synchronous, active-high
//  InstrRAMenable         in   1   instruction RAM enable from controller
//  InstrRAMread_en        in   1   instruction RAM read request from controller
//  PCounterIncb_in        in   1   PC increment amount (0 = re-fetch same, 1 = next word)
//  PCounterInccontrol_in  in   1   1 = load PC from branch_target instead of incrementing
//  branch_target          in   AW  PC load value when PCounterInccontrol_in = 1
//  StageRegld_str         in   1   stage register load strobe (level held by controller)
//  prog_we                in   1   program-load write enable (bench / boot loader)
//  prog_addr              in   AW  program-load address
//  prog_data              in   IW  program-load data
//  StageRegInstr_out      out  5   opcode field of stage register
//  StageRegAddrMode_out   out  3   address-mode field of stage register
//  StageRegAddr_out       out  8   address/operand field of stage register
//  pc_out                 out  AW  current PC
//  fetch_pending          out  1   1 while a fetched word waits in read buffer (state HOLD)
// BEHAVIOUR
//  Reset (reset=1 at clk edge): pc=0, read buffer=0, stage register=0 (all three field
//   outputs 0), fetch_pending=0, state=IDLE, ld_prev=0. RAM contents NOT cleared.
//   Reset mid-fetch aborts: buffered word discarded, no stage load, PC back to 0.
//  Read accept: rd_req = InstrRAMenable & InstrRAMread_en. Accepted only in IDLE.
//  FSM (2 states):
//   IDLE: if rd_req -> buffer <= mem[pc]; pc <= next_pc; state <= HOLD. Else hold.
//   HOLD: if ld_edge -> stage register <= buffer; state <= IDLE. rd_req ignored (no PC
//         change, buffer unchanged) while in HOLD.
//  next_pc = PCounterInccontrol_in ? branch_target : pc + PCounterIncb_in, modulo 2**AW
//   (pc = 2**AW-1 with increment wraps to 0). Inccontrol/Incb sampled only in the
//   accepting cycle; their levels in any other cycle have no effect.
//  ld_edge = StageRegld_str & ~ld_prev; ld_prev <= StageRegld_str every cycle. Level-held
//   strobe loads once per rising edge; rising edge while IDLE is ignored (no load).
//  Latency: accept at edge N -> fetch_pending=1 after N; ld rising seen at edge M>N ->
//   field outputs valid after M. Minimum accept-to-stage = 2 edges. Back-to-back: IDLE
//   re-entered after load, so rd_req in the next cycle is accepted.
//  Program port: prog_we writes mem[prog_addr] <= prog_data at clk edge, any state.
//   Same-cycle write and accepted read to same address: read returns OLD word.
//  Outputs registered; field outputs change only on stage load or reset.
//  Inputs never X-propagate into state: undefined strobe levels treated as per sim value.
// TESTING
//  Load mem[0]=16'h8A05, mem[1]=16'h1234; reset; rd_req cycle, ld 0->1 two cycles later
//   -> Instr=5'h11, AddrMode=3'h2, Addr=8'h05, pc_out=1, fetch_pending 1 then 0.
//  Controller loop (read, ld=0, ld=1) x3 with incb=1 -> pc 1,2,3; fields track mem[0..2];
//   StageRegld_str held high 2 extra cycles -> no second load.
//  pc=8'hFF, incb=1 accept -> pc_out=0; incb=0 accept -> pc unchanged, same word refetched.
//  Inccontrol=1, branch_target=8'h40 at accept -> pc_out=8'h40; inccontrol=1 in a
//   non-accept cycle -> pc unchanged. rd_req held in HOLD -> pc/buffer unchanged.
//  Accept while prog_we writes same addr with 16'hFFFF -> stage gets old word; next fetch
//   of that addr (after branch back) gets 16'hFFFF.
//  Reset asserted in HOLD before ld edge -> pc=0, fields 0, fetch_pending=0; following
//   ld edge causes no load.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction-side responder to the processor controller. Holds the program
// counter, the instruction RAM, a one-word read buffer and the stage
// (instruction) register whose fields the controller sequences on.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no word buffered; a read request fetches mem[pc], advances pc
//   S_HOLD | fetched word waits in the read buffer for a ld strobe edge
module instr_fetch_unit #(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          InstrRAMenable,
    input  logic          InstrRAMread_en,
    input  logic          PCounterIncb_in,
    input  logic          PCounterInccontrol_in,
    input  logic [AW-1:0] branch_target,
    input  logic          StageRegld_str,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [4:0]    StageRegInstr_out,
    output logic [2:0]    StageRegAddrMode_out,
    output logic [7:0]    StageRegAddr_out,
    output logic [AW-1:0] pc_out,
    output logic          fetch_pending
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_buf;
    logic [IW-1:0] r_stage;
    logic          r_pending;
    logic          r_ld_prev;
    logic [IW-1:0] r_mem [0:(2**AW)-1];

    logic          w_rd_req;
    logic          w_ld_edge;
    logic [AW-1:0] w_next_pc;

    // Request decode, strobe edge detect and next-PC selection.
    always_comb begin
        w_rd_req  = InstrRAMenable & InstrRAMread_en;
        w_ld_edge = StageRegld_str & ~r_ld_prev;
        if (PCounterInccontrol_in) begin
            w_next_pc = branch_target;
        end else begin
            w_next_pc = r_pc + AW'(PCounterIncb_in);
        end
    end

    // Program-load port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Level history of the load strobe, so a held strobe loads only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_prev <= 1'b0;
        end else begin
            r_ld_prev <= StageRegld_str;
        end
    end

    // Fetch/stage FSM. The buffer read sees the pre-write RAM word when a
    // program write hits the same address in the accepting cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_buf     <= '0;
            r_stage   <= '0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_req) begin
                        r_buf     <= r_mem[r_pc];
                        r_pc      <= w_next_pc;
                        r_pending <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_ld_edge) begin
                        r_stage   <= r_buf;
                        r_pending <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        StageRegInstr_out    = r_stage[15:11];
        StageRegAddrMode_out = r_stage[10:8];
        StageRegAddr_out     = r_stage[7:0];
        pc_out               = r_pc;
        fetch_pending        = r_pending;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrRAMenable;
    logic        InstrRAMread_en;
    logic        PCounterIncb_in;
    logic        PCounterInccontrol_in;
    logic [7:0]  branch_target;
    logic        StageRegld_str;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  StageRegInstr_out;
    logic [2:0]  StageRegAddrMode_out;
    logic [7:0]  StageRegAddr_out;
    logic [7:0]  pc_out;
    logic        fetch_pending;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.IW(16), .AW(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .InstrRAMenable        (InstrRAMenable),
        .InstrRAMread_en       (InstrRAMread_en),
        .PCounterIncb_in       (PCounterIncb_in),
        .PCounterInccontrol_in (PCounterInccontrol_in),
        .branch_target         (branch_target),
        .StageRegld_str        (StageRegld_str),
        .prog_we               (prog_we),
        .prog_addr             (prog_addr),
        .prog_data             (prog_data),
        .StageRegInstr_out     (StageRegInstr_out),
        .StageRegAddrMode_out  (StageRegAddrMode_out),
        .StageRegAddr_out      (StageRegAddr_out),
        .pc_out                (pc_out),
        .fetch_pending         (fetch_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fields();
        return {StageRegInstr_out, StageRegAddrMode_out, StageRegAddr_out};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // One accepting cycle with the given PC-control levels, then idle levels.
    task automatic accept(input logic incb, input logic ctl, input logic [7:0] tgt);
        InstrRAMenable = 1'b1; InstrRAMread_en = 1'b1;
        PCounterIncb_in = incb; PCounterInccontrol_in = ctl; branch_target = tgt;
        tick();
        InstrRAMenable = 1'b0; InstrRAMread_en = 1'b0;
        PCounterIncb_in = 1'b0; PCounterInccontrol_in = 1'b0; branch_target = 8'h00;
    endtask

    // Strobe low for one edge, then high: loads on the second edge.
    task automatic load_edge();
        StageRegld_str = 1'b0;
        tick();
        StageRegld_str = 1'b1;
        tick();
    endtask

    logic [15:0] loop_words [3];

    initial begin
        reset = 1'b1;
        InstrRAMenable = 1'b0; InstrRAMread_en = 1'b0;
        PCounterIncb_in = 1'b0; PCounterInccontrol_in = 1'b0;
        branch_target = 8'h00; StageRegld_str = 1'b0;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
        loop_words[0] = 16'h8A05;
        loop_words[1] = 16'h1234;
        loop_words[2] = 16'hABCD;

        // Program load happens while reset is held; RAM is not cleared by it.
        wr(8'h00, 16'h8A05);
        wr(8'h01, 16'h1234);
        wr(8'h02, 16'hABCD);
        wr(8'h03, 16'h0F0F);
        wr(8'h04, 16'h0444);
        wr(8'h40, 16'h5A5A);
        wr(8'h41, 16'h1111);
        wr(8'hFF, 16'hC3C3);
        reset = 1'b0;

        chk("reset_fields", fields(), 16'h0000);
        chk("reset_pc", {8'h00, pc_out}, 16'h0000);
        chk("reset_pending", {15'd0, fetch_pending}, 16'h0000);

        // First fetch: word 8A05 -> opcode 11, mode 2, addr 05.
        accept(1'b1, 1'b0, 8'h00);
        chk("f1_pending_set", {15'd0, fetch_pending}, 16'h0001);
        chk("f1_pc", {8'h00, pc_out}, 16'h0001);
        chk("f1_fields_before_load", fields(), 16'h0000);
        load_edge();
        chk("f1_instr", {11'd0, StageRegInstr_out}, 16'h0011);
        chk("f1_mode", {13'd0, StageRegAddrMode_out}, 16'h0002);
        chk("f1_addr", {8'h00, StageRegAddr_out}, 16'h0005);
        chk("f1_pending_clr", {15'd0, fetch_pending}, 16'h0000);

        // Controller loop from a fresh reset.
        StageRegld_str = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            accept(1'b1, 1'b0, 8'h00);
            chk("loop_pc", {8'h00, pc_out}, 16'(i + 1));
            load_edge();
            chk("loop_fields", fields(), loop_words[i]);
        end

        // Strobe still high across a new accept: no edge, so no load.
        accept(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        chk("held_ld_no_load", fields(), 16'hABCD);
        chk("held_ld_pending", {15'd0, fetch_pending}, 16'h0001);
        load_edge();
        chk("held_ld_then_edge", fields(), 16'h0F0F);

        // Branch to FF, then increment wraps to 0, then incb=0 refetches.
        accept(1'b0, 1'b1, 8'hFF);
        chk("br_ff_pc", {8'h00, pc_out}, 16'h00FF);
        load_edge();
        chk("br_ff_word", fields(), 16'h0444);
        accept(1'b1, 1'b0, 8'h00);
        chk("wrap_pc", {8'h00, pc_out}, 16'h0000);
        load_edge();
        chk("wrap_word", fields(), 16'hC3C3);
        accept(1'b0, 1'b0, 8'h00);
        chk("incb0_pc", {8'h00, pc_out}, 16'h0000);
        load_edge();
        chk("incb0_word", fields(), 16'h8A05);
        accept(1'b0, 1'b0, 8'h00);
        chk("incb0_again_pc", {8'h00, pc_out}, 16'h0000);
        load_edge();
        chk("incb0_again_word", fields(), 16'h8A05);

        // Branch to 40; branch control outside an accept does nothing.
        accept(1'b1, 1'b1, 8'h40);
        chk("br_40_pc", {8'h00, pc_out}, 16'h0040);
        load_edge();
        PCounterInccontrol_in = 1'b1; branch_target = 8'h10; PCounterIncb_in = 1'b1;
        tick();
        PCounterInccontrol_in = 1'b0; branch_target = 8'h00; PCounterIncb_in = 1'b0;
        chk("ctl_no_accept_pc", {8'h00, pc_out}, 16'h0040);

        // Read request held during HOLD is ignored.
        accept(1'b1, 1'b0, 8'h00);
        chk("hold_accept_pc", {8'h00, pc_out}, 16'h0041);
        InstrRAMenable = 1'b1; InstrRAMread_en = 1'b1;
        PCounterInccontrol_in = 1'b1; branch_target = 8'h10;
        StageRegld_str = 1'b0;
        tick();
        tick();
        InstrRAMenable = 1'b0; InstrRAMread_en = 1'b0;
        PCounterInccontrol_in = 1'b0; branch_target = 8'h00;
        chk("hold_rd_pc", {8'h00, pc_out}, 16'h0041);
        chk("hold_rd_pending", {15'd0, fetch_pending}, 16'h0001);
        load_edge();
        chk("hold_rd_word", fields(), 16'h5A5A);

        // Accept with a same-address program write: old word is read.
        InstrRAMenable = 1'b1; InstrRAMread_en = 1'b1;
        PCounterInccontrol_in = 1'b1; branch_target = 8'h41;
        prog_we = 1'b1; prog_addr = 8'h41; prog_data = 16'hFFFF;
        tick();
        InstrRAMenable = 1'b0; InstrRAMread_en = 1'b0;
        PCounterInccontrol_in = 1'b0; branch_target = 8'h00;
        prog_we = 1'b0;
        chk("coll_pc", {8'h00, pc_out}, 16'h0041);
        load_edge();
        chk("coll_old_word", fields(), 16'h1111);
        accept(1'b1, 1'b0, 8'h00);
        chk("coll_next_pc", {8'h00, pc_out}, 16'h0042);
        load_edge();
        chk("coll_new_word", fields(), 16'hFFFF);

        // Reset in HOLD discards the buffered word.
        StageRegld_str = 1'b0;
        accept(1'b1, 1'b0, 8'h00);
        chk("rst_hold_pre_pc", {8'h00, pc_out}, 16'h0043);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_hold_pc", {8'h00, pc_out}, 16'h0000);
        chk("rst_hold_fields", fields(), 16'h0000);
        chk("rst_hold_pending", {15'd0, fetch_pending}, 16'h0000);
        StageRegld_str = 1'b1;
        tick();
        tick();
        chk("rst_hold_no_load", fields(), 16'h0000);
        chk("rst_hold_pending2", {15'd0, fetch_pending}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
